// File: rtl/bp_be_stride_prefetch_issuer.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_stride_prefetch_issuer
// Brief    : Expands one loop-inference packet {remaining iterations, pc,
//            effective address, stride} into a bounded stream of line-aligned
//            prefetch addresses for the D$ prefetch queue. A request whose
//            line matches the previously requested line is suppressed.
// Revision : 1.0 - initial release
// ============================================================================
module bp_be_stride_prefetch_issuer
  #(parameter int vaddr_width_p       = 39
  , parameter int output_range_p      = 8
  , parameter int stride_width_p      = 8
  , parameter int max_prefetch_p      = 16
  , parameter int line_offset_width_p = 6
  )
  (input  logic                      clk_i
  , input  logic                      reset_n_i

  // Loop-inference packet
  , input  logic                      v_i
  , input  logic [output_range_p-1:0] remaining_iterations_i
  , input  logic [vaddr_width_p-1:0]  pc_i
  , input  logic [vaddr_width_p-1:0]  eff_addr_i
  , input  logic [stride_width_p-1:0] stride_i
  , output logic                      yumi_o

  // Prefetch request stream
  , output logic                      pf_v_o
  , output logic [vaddr_width_p-1:0]  pf_addr_o
  , input  logic                      pf_ready_and_i

  // Control / status
  , input  logic                      flush_i
  , output logic                      busy_o
  );

  // Width of the line-number field and of the stride sign extension
  localparam int c_line_width = vaddr_width_p - line_offset_width_p;
  localparam int c_sext_width = vaddr_width_p - stride_width_p;

  // Iteration cap and unit count, sized to the iteration counter
  localparam logic [output_range_p-1:0] c_max_count = output_range_p'(max_prefetch_p);
  localparam logic [output_range_p-1:0] c_one       = output_range_p'(1);

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_run  = 1'b1
  } state_e;

  state_e                      r_state;
  logic [output_range_p-1:0]   r_count;
  logic [vaddr_width_p-1:0]    r_addr;
  logic [stride_width_p-1:0]   r_stride;
  logic [vaddr_width_p-1:0]    r_pc;
  logic [c_line_width-1:0]     r_last_line;
  logic [vaddr_width_p-1:0]    r_last_pc;
  logic                        r_last_pc_v;

  logic                        w_idle;
  logic                        w_run;
  logic                        w_drop;
  logic                        w_same;
  logic                        w_step;
  logic                        w_last_iter;
  logic                        w_pf_v;
  logic [c_line_width-1:0]     w_addr_line;
  logic [c_line_width-1:0]     w_eff_line;
  logic [vaddr_width_p-1:0]    w_stride_sext_in;
  logic [vaddr_width_p-1:0]    w_stride_sext_r;
  logic [output_range_p-1:0]   w_start_count;

  assign w_idle = (r_state == e_idle);
  assign w_run  = (r_state == e_run);

  // Strides are signed byte offsets; address arithmetic wraps modulo 2^vaddr
  assign w_stride_sext_in = {{c_sext_width{stride_i[stride_width_p-1]}}, stride_i};
  assign w_stride_sext_r  = {{c_sext_width{r_stride[stride_width_p-1]}}, r_stride};

  assign w_addr_line = r_addr[vaddr_width_p-1:line_offset_width_p];
  assign w_eff_line  = eff_addr_i[vaddr_width_p-1:line_offset_width_p];

  // A packet is discarded if it predicts nothing, or if it repeats the loop
  // whose expansion just completed (that stream is already in flight)
  assign w_drop = (remaining_iterations_i == '0)
                | (r_last_pc_v && (pc_i == r_last_pc));

  assign w_start_count = (remaining_iterations_i > c_max_count) ? c_max_count
                                                                : remaining_iterations_i;

  // An iteration landing in the last requested line needs no request and
  // retires immediately; otherwise it waits for the prefetch queue
  assign w_same      = (w_addr_line == r_last_line);
  assign w_pf_v      = w_run & ~w_same & ~flush_i;
  assign w_step      = w_run & ~flush_i & (w_same | pf_ready_and_i);
  assign w_last_iter = (r_count <= c_one);

  // Consume is zero-latency in IDLE; reset and flush both suppress it
  assign yumi_o    = reset_n_i & w_idle & v_i & ~flush_i;
  assign pf_v_o    = w_pf_v;
  assign pf_addr_o = {w_addr_line, {line_offset_width_p{1'b0}}};
  assign busy_o    = w_run;

  // FSM and datapath: accept a packet, walk one iteration per cycle, abort on flush
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= e_idle;
      r_count     <= '0;
      r_addr      <= '0;
      r_stride    <= '0;
      r_pc        <= '0;
      r_last_line <= '0;
      r_last_pc   <= '0;
      r_last_pc_v <= 1'b0;
    end else if (flush_i) begin
      r_state     <= e_idle;
      r_count     <= '0;
      r_last_pc_v <= 1'b0;
    end else begin
      case (r_state)
        e_idle: begin
          if (v_i && !w_drop) begin
            r_addr      <= eff_addr_i + w_stride_sext_in;
            r_count     <= w_start_count;
            r_stride    <= stride_i;
            r_pc        <= pc_i;
            r_last_line <= w_eff_line;
            r_state     <= e_run;
          end
        end
        e_run: begin
          if (w_step) begin
            r_addr  <= r_addr + w_stride_sext_r;
            r_count <= (r_count != '0) ? (r_count - c_one) : '0;
            if (!w_same) begin
              r_last_line <= w_addr_line;
            end
            if (w_last_iter) begin
              r_state     <= e_idle;
              r_last_pc   <= r_pc;
              r_last_pc_v <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= e_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
